// File: rtl/cnt_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_timer_pkg
// Description : Shared state and command encodings for the interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cnt_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_core
// Description : WIDTH-bit binary up-counter, synchronous clear over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_timer_ctrl
// Description : Command-driven interval timer: prescaler, FSM and counter.
// Revision    : 1.0 - initial release
// ============================================================================
import cnt_timer_pkg::*;

module cnt_timer_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [PRE_W-1:0] cmd_prescale,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done_pulse,
    output logic             err_pulse
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   r_pre;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic [WIDTH-1:0]   r_limit;
    logic               r_mode;
    logic [PRE_W-1:0]   r_prescale;
    logic               w_latch;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_accept;
    logic               w_tick;
    logic               w_term;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_tick   = (r_state == ST_RUN) && (r_pre == r_prescale);
    assign w_term   = w_tick && (count == r_limit);

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (r_state == ST_RUN) begin
            w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
            if (w_term) begin
                w_done_nxt = 1'b1;
                if (r_mode) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end else if (w_tick) begin
                w_cnt_en = 1'b1;
            end
        end

        // Commands override the tick, except that a terminal event survives STOP.
        if (w_accept) begin
            case (cmd_op)
                OP_START: begin
                    case (r_state)
                        ST_IDLE, ST_DONE: begin
                            w_latch     = 1'b1;
                            w_cnt_clr   = 1'b1;
                            w_pre_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end
                        ST_PAUSE: w_state_nxt = ST_RUN;
                        default:  w_err_nxt   = 1'b1;
                    endcase
                end
                OP_STOP: begin
                    if (r_state == ST_RUN) begin
                        if (!w_term) begin
                            w_state_nxt = ST_PAUSE;
                            w_cnt_en    = 1'b0;
                            w_pre_nxt   = r_pre;
                        end else if (r_mode) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end
                end
                OP_CLEAR: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                    w_cnt_en    = 1'b0;
                    w_pre_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
                OP_NOP:  ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pre      <= '0;
            r_limit    <= '0;
            r_mode     <= 1'b0;
            r_prescale <= '0;
            cmd_ready  <= 1'b0;
            running    <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre      <= w_pre_nxt;
            cmd_ready  <= 1'b1;
            running    <= (w_state_nxt == ST_RUN);
            done_pulse <= w_done_nxt;
            err_pulse  <= w_err_nxt;
            if (w_latch) begin
                r_limit    <= cmd_limit;
                r_mode     <= cmd_mode;
                r_prescale <= cmd_prescale;
            end
        end
    end

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk (clk),
        .rst (rst),
        .clr (w_cnt_clr),
        .en  (w_cnt_en),
        .q   (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cnt_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_timer_ctrl
// Description : Directed self-checking bench for cnt_timer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_timer_ctrl;

    localparam int WIDTH = 4;
    localparam int PRE_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_mode;
    logic [WIDTH-1:0] cmd_limit;
    logic [PRE_W-1:0] cmd_prescale;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done_pulse;
    logic             err_pulse;

    int n_tests;
    int n_fail;

    cnt_timer_ctrl #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_mode     (cmd_mode),
        .cmd_limit    (cmd_limit),
        .cmd_prescale (cmd_prescale),
        .count        (count),
        .running      (running),
        .done_pulse   (done_pulse),
        .err_pulse    (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command so it is accepted on the next edge; returns just after that edge.
    task automatic cmd(input logic [1:0] op, input logic mode,
                       input logic [WIDTH-1:0] lim, input logic [PRE_W-1:0] pre);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_mode     = mode;
        cmd_limit    = lim;
        cmd_prescale = pre;
        step();
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
    endtask

    logic [WIDTH-1:0] ar_seq [13];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_mode     = 1'b0;
        cmd_limit    = '0;
        cmd_prescale = '0;
        ar_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};

        // Reset state
        repeat (2) step();
        check("rst_ready", {31'd0, cmd_ready}, 0);
        check("rst_count", {28'd0, count}, 0);
        check("rst_running", {31'd0, running}, 0);
        check("rst_done", {31'd0, done_pulse}, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'd0, cmd_ready}, 1);

        // One-shot, limit 3, prescale 0
        cmd(2'b01, 1'b0, 4'd3, 4'd0);
        check("os_n_count", {28'd0, count}, 0);
        check("os_n_running", {31'd0, running}, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("os_count", {28'd0, count}, i);
            check("os_nodone", {31'd0, done_pulse}, 0);
        end
        step();
        check("os_done", {31'd0, done_pulse}, 1);
        check("os_hold", {28'd0, count}, 3);
        check("os_running", {31'd0, running}, 0);
        step();
        check("os_done_1cyc", {31'd0, done_pulse}, 0);
        check("os_hold2", {28'd0, count}, 3);

        // Auto-reload, limit 2, prescale 1
        cmd(2'b11, 1'b0, 4'd0, 4'd0);
        cmd(2'b01, 1'b1, 4'd2, 4'd1);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step();
            check("ar_count", {28'd0, count}, {28'd0, ar_seq[i]});
            check("ar_done", {31'd0, done_pulse}, (i == 6 || i == 12) ? 1 : 0);
            check("ar_running", {31'd0, running}, 1);
        end
        cmd(2'b11, 1'b0, 4'd0, 4'd0);
        check("clr_count", {28'd0, count}, 0);
        check("clr_running", {31'd0, running}, 0);

        // Pause/resume, one-shot, limit 5, plus START while RUN
        cmd(2'b01, 1'b0, 4'd5, 4'd0);
        step();
        step();
        check("pr_count2", {28'd0, count}, 2);
        cmd(2'b10, 1'b0, 4'd0, 4'd0);
        check("pr_stop_count", {28'd0, count}, 2);
        check("pr_stop_running", {31'd0, running}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("pr_hold_count", {28'd0, count}, 2);
            check("pr_hold_running", {31'd0, running}, 0);
        end
        cmd(2'b01, 1'b1, 4'd9, 4'd7);
        check("pr_resume_running", {31'd0, running}, 1);
        step();
        check("pr_resume_count", {28'd0, count}, 3);
        cmd(2'b01, 1'b0, 4'd1, 4'd0);
        check("err_pulse", {31'd0, err_pulse}, 1);
        check("err_count", {28'd0, count}, 4);
        step();
        check("err_1cyc", {31'd0, err_pulse}, 0);
        check("err_count_next", {28'd0, count}, 5);
        step();
        check("pr_done", {31'd0, done_pulse}, 1);
        check("pr_final", {28'd0, count}, 5);
        check("pr_final_running", {31'd0, running}, 0);

        // STOP in IDLE is silently ignored
        cmd(2'b11, 1'b0, 4'd0, 4'd0);
        cmd(2'b10, 1'b0, 4'd0, 4'd0);
        check("idle_stop_err", {31'd0, err_pulse}, 0);
        check("idle_stop_running", {31'd0, running}, 0);
        check("idle_stop_count", {28'd0, count}, 0);

        // CLEAR on the terminal tick, limit 0
        cmd(2'b01, 1'b0, 4'd0, 4'd0);
        cmd(2'b11, 1'b0, 4'd0, 4'd0);
        check("clrcol_done", {31'd0, done_pulse}, 0);
        check("clrcol_running", {31'd0, running}, 0);
        check("clrcol_count", {28'd0, count}, 0);
        step();
        check("clrcol_done2", {31'd0, done_pulse}, 0);
        check("clrcol_running2", {31'd0, running}, 0);

        // STOP on the terminal tick, auto-reload limit 1
        cmd(2'b01, 1'b1, 4'd1, 4'd0);
        step();
        check("stopcol_pre", {28'd0, count}, 1);
        cmd(2'b10, 1'b0, 4'd0, 4'd0);
        check("stopcol_done", {31'd0, done_pulse}, 1);
        check("stopcol_count", {28'd0, count}, 0);
        check("stopcol_running", {31'd0, running}, 0);
        step();
        step();
        check("stopcol_paused", {28'd0, count}, 0);
        check("stopcol_paused_run", {31'd0, running}, 0);

        // Async reset mid-run
        cmd(2'b11, 1'b0, 4'd0, 4'd0);
        cmd(2'b01, 1'b0, 4'd15, 4'd0);
        repeat (3) step();
        check("ar_pre_rst", {28'd0, count}, 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_count", {28'd0, count}, 0);
        check("async_running", {31'd0, running}, 0);
        check("async_ready", {31'd0, cmd_ready}, 0);
        step();
        rst = 1'b0;
        check("ready_still_low", {31'd0, cmd_ready}, 0);
        step();
        check("ready_back", {31'd0, cmd_ready}, 1);

        // Full-range one-shot, limit 15
        cmd(2'b01, 1'b0, 4'd15, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("full_count", {28'd0, count}, i);
        end
        step();
        check("full_done", {31'd0, done_pulse}, 1);
        check("full_nowrap", {28'd0, count}, 15);
        step();
        check("full_hold", {28'd0, count}, 15);
        check("full_running", {31'd0, running}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
